// File: rtl/cpu_pkg.sv
// Shared types for the parametrised accumulator CPU: opcodes, FSM states, ALU result.
package cpu_pkg;

  // Widest data path the ALU result struct can carry; DW must not exceed this.
  localparam int DW_MAX = 32;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_XCHG = 4'h2, OP_LDA = 4'h3,
    OP_RCR  = 4'h4, OP_IN   = 4'h5, OP_OUT  = 4'h6, OP_AND = 4'h7,
    OP_TEST = 4'h8, OP_OR   = 4'h9, OP_XOR  = 4'hA, OP_PUSH = 4'hB,
    OP_POP  = 4'hC, OP_JZ   = 4'hD, OP_STA  = 4'hE, OP_HLT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    IDLE, FETCH, EXEC, WAIT_IN, WAIT_OUT, HALT, FAULT
  } state_e;

  typedef struct packed {
    logic [DW_MAX-1:0] result;
    logic              c;
    logic              z;
    logic              s;
  } alu_res_t;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: arithmetic/logic result plus carry, zero and sign for the current opcode.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DW = 8
) (
  input  opcode_e       op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          c_in,
  output alu_res_t      res
);

  logic [DW:0]   sum;
  logic [DW-1:0] r;

  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    r   = '0;
    res = '0;
    case (op)
      OP_ADD:          begin r = sum[DW-1:0];        res.c = sum[DW]; end
      OP_SUB:          begin r = a - b;              res.c = (a < b); end
      OP_AND, OP_TEST: r = a & b;
      OP_XOR:          r = a ^ b;
      // rotate B right through carry
      OP_RCR:          begin r = {c_in, b[DW-1:1]};  res.c = b[0];    end
      default:         r = '0;
    endcase
    res.result = DW_MAX'(r);
    res.z      = (r == '0);
    res.s      = r[DW-1];
  end

endmodule

// File: rtl/param_accum_cpu.sv
// Accumulator CPU top: load port, run/halt FSM, program/data/stack memories and I/O handshakes.
module param_accum_cpu
  import cpu_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 4,
  parameter int SW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_en,
  input  logic [3+AW:0] load_prog,
  input  logic [DW-1:0] load_data,
  input  logic          start,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] pc,
  output logic          halted,
  output logic          fault,
  output logic          s_flag,
  output logic          z_flag,
  output logic          c_flag
);

  localparam logic [AW-1:0] PC_MAX   = {AW{1'b1}};
  localparam logic [SW:0]   SP_EMPTY = {1'b1, {SW{1'b0}}};

  state_e          state, state_nx;
  logic [3+AW:0]   ir;
  opcode_e         opc;
  logic [AW-1:0]   opnd;
  logic [DW-1:0]   reg_a, reg_b, alu_b, dmem_rd;
  logic [AW-1:0]   load_ptr;
  logic [SW:0]     sp;
  logic            stk_fault, retire, jump;
  alu_res_t        alu_r;
  logic            unused_alu_hi;

  logic [3+AW:0]   prog  [2**AW];
  logic [DW-1:0]   dmem  [2**AW];
  logic [DW-1:0]   stack [2**SW];

  assign opc     = opcode_e'(ir[3+AW:AW]);
  assign opnd    = ir[AW-1:0];
  assign dmem_rd = dmem[opnd];
  assign alu_b   = (opc == OP_XOR) ? dmem_rd : reg_b;
  assign unused_alu_hi = ^alu_r.result;

  cpu_alu #(.DW(DW)) u_alu (
    .op   (opc),
    .a    (reg_a),
    .b    (alu_b),
    .c_in (c_flag),
    .res  (alu_r)
  );

  // A faulting stack op leaves every architectural register untouched.
  assign stk_fault = (opc == OP_PUSH && sp == '0) || (opc == OP_POP && sp == SP_EMPTY);
  assign jump      = (state == EXEC) && (opc == OP_JZ) && z_flag;

  always_comb begin
    retire = 1'b0;
    case (state)
      EXEC:     retire = !(opc inside {OP_IN, OP_OUT, OP_HLT}) && !stk_fault;
      WAIT_IN:  retire = in_valid;
      WAIT_OUT: retire = out_ready;
      default:  retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start && !load_en) state_nx = FETCH;
      FETCH: state_nx = EXEC;
      EXEC: begin
        if (stk_fault)             state_nx = FAULT;
        else if (opc == OP_IN)     state_nx = WAIT_IN;
        else if (opc == OP_OUT)    state_nx = WAIT_OUT;
        else if (opc == OP_HLT)    state_nx = HALT;
      end
      default: ;
    endcase
    // falling off the last program word halts instead of wrapping
    if (retire) state_nx = (jump || pc != PC_MAX) ? FETCH : HALT;
  end

  always_comb begin
    in_ready  = (state == WAIT_IN);
    out_valid = (state == WAIT_OUT);
    halted    = (state == HALT);
    fault     = (state == FAULT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= '0;
      load_ptr <= '0;
      ir       <= '0;
      reg_a    <= '0;
      reg_b    <= '0;
      sp       <= SP_EMPTY;
      out_data <= '0;
      c_flag   <= 1'b0;
      z_flag   <= 1'b0;
      s_flag   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_en) begin
            if (load_ptr != PC_MAX) load_ptr <= load_ptr + 1'b1;
          end else if (start) begin
            pc <= '0;
          end
        end
        FETCH: ir <= prog[pc];
        EXEC: if (!stk_fault) begin
          case (opc)
            OP_ADD, OP_SUB, OP_AND: begin
              reg_a <= alu_r.result[DW-1:0];
              {c_flag, z_flag, s_flag} <= {alu_r.c, alu_r.z, alu_r.s};
            end
            OP_TEST: {c_flag, z_flag, s_flag} <= {alu_r.c, alu_r.z, alu_r.s};
            OP_XOR: begin
              reg_a <= alu_r.result[DW-1:0];
              {z_flag, s_flag} <= {alu_r.z, alu_r.s};
            end
            OP_XCHG: begin reg_a <= reg_b; reg_b <= reg_a; end
            OP_LDA: begin
              reg_a  <= dmem_rd;
              z_flag <= (dmem_rd == '0);
              s_flag <= dmem_rd[DW-1];
            end
            OP_RCR: begin reg_b <= alu_r.result[DW-1:0]; c_flag <= alu_r.c; end
            OP_OR:  reg_b <= reg_b | dmem_rd;
            OP_OUT: out_data <= reg_a;
            OP_PUSH: sp <= sp - 1'b1;
            OP_POP: begin reg_b <= stack[sp[SW-1:0]]; sp <= sp + 1'b1; end
            default: ;
          endcase
        end
        WAIT_IN: if (in_valid) begin
          reg_a  <= in_data;
          z_flag <= (in_data == '0);
          s_flag <= in_data[DW-1];
        end
        default: ;
      endcase
      if (retire) pc <= jump ? opnd : ((pc != PC_MAX) ? pc + 1'b1 : pc);
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && load_en) begin
      prog[load_ptr] <= load_prog;
      dmem[load_ptr] <= load_data;
    end else if (state == EXEC && opc == OP_STA) begin
      dmem[opnd] <= reg_a;
    end
  end

  always_ff @(posedge clk) begin
    if (state == EXEC && opc == OP_PUSH && !stk_fault) stack[SW'(sp - 1'b1)] <= reg_b;
  end

endmodule

// File: tb/tb_param_accum_cpu.sv
// Scoreboard bench: an instruction-level interpreter predicts OUT values and final state.
module tb_param_accum_cpu;
  localparam int DW = 8, AW = 4, SW = 4;

  logic clk = 1'b0, reset = 1'b0, load_en = 1'b0, start = 1'b0;
  logic [3+AW:0] load_prog = '0;
  logic [DW-1:0] load_data = '0, in_data = '0, out_data;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [AW-1:0] pc;
  logic halted, fault, s_flag, z_flag, c_flag;

  param_accum_cpu #(.DW(DW), .AW(AW), .SW(SW)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_prog(load_prog),
    .load_data(load_data), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .pc(pc), .halted(halted), .fault(fault),
    .s_flag(s_flag), .z_flag(z_flag), .c_flag(c_flag)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] d; logic c, z, s; } ent_t;
  ent_t       exp_q[$];
  logic [7:0] in_q[$];
  logic [7:0] mprog[16], mdata[16];
  logic [7:0] pq[$], dq[$];
  int  total = 0, bad = 0;
  bit  out_stall = 0, in_zero = 0;
  int  e_pc, e_halt, e_fault, e_c, e_z, e_s;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Sink: random backpressure; a handshake seen here completes at the next rising edge.
  always @(negedge clk) begin
    ent_t e;
    out_ready = out_stall ? 1'b0 : ($urandom_range(2) != 0);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL out_extra act=%0h exp=none", out_data);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(e.d));
        chk("out_flags", 32'({c_flag, z_flag, s_flag}), 32'({e.c, e.z, e.s}));
      end
    end
  end

  // Source: offers queued IN values with random gaps, garbage when idle.
  always @(negedge clk) begin
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    if (in_q.size() > 0 && $urandom_range(3) != 0) begin
      in_valid = 1'b1;
      in_data  = in_q[0];
      if (in_ready) void'(in_q.pop_front());
    end
  end

  // Instruction-level interpreter of the ISA.
  task automatic model();
    int p = 0, a = 0, b = 0, c = 0, z = 0, s = 0, sp = 16, t, n = 0, opc, op;
    int stk[16], d[16];
    bit jmp;
    ent_t e;
    for (int i = 0; i < 16; i++) d[i] = int'(mdata[i]);
    e_halt = 0; e_fault = 0;
    while (n < 5000) begin
      opc = int'(mprog[p][7:4]); op = int'(mprog[p][3:0]); jmp = 0;
      case (opc)
        0:  begin t = a + b; c = (t > 255) ? 1 : 0; a = t & 255; end
        1:  begin c = (a < b) ? 1 : 0; a = (a - b) & 255; end
        2:  begin t = a; a = b; b = t; end
        3:  a = d[op];
        4:  begin t = (c << 7) | (b >> 1); c = b & 1; b = t; end
        5:  begin a = in_zero ? 0 : int'($urandom_range(255)); in_q.push_back(8'(a)); end
        6:  begin e.d = 8'(a); e.c = c[0]; e.z = z[0]; e.s = s[0]; exp_q.push_back(e); end
        7:  begin a = a & b; c = 0; end
        8:  begin t = a & b; c = 0; z = (t == 0) ? 1 : 0; s = t >> 7; end
        9:  b = b | d[op];
        10: a = a ^ d[op];
        11: if (sp == 0) e_fault = 1; else begin sp--; stk[sp] = b; end
        12: if (sp == 16) e_fault = 1; else begin b = stk[sp]; sp++; end
        13: if (z != 0) begin p = op; jmp = 1; end
        14: d[op] = a;
        default: e_halt = 1;
      endcase
      if (opc inside {0, 1, 3, 5, 7, 10}) begin z = (a == 0) ? 1 : 0; s = a >> 7; end
      if (e_halt != 0 || e_fault != 0) break;
      if (!jmp) begin
        if (p == 15) begin e_halt = 1; break; end
        p++;
      end
      n++;
    end
    e_pc = p; e_c = c; e_z = z; e_s = s;
  endtask

  task automatic pad();
    while (pq.size() < 16) pq.push_back(8'hF0);
    while (dq.size() < pq.size()) dq.push_back(8'h00);
  endtask

  // Reset, load (load pointer saturates at the last entry), predict.
  task automatic prep(input bit st_last);
    int idx;
    pad();
    reset = 1'b0; exp_q.delete(); in_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int k = 0; k < pq.size(); k++) begin
      load_en = 1'b1; load_prog = pq[k]; load_data = dq[k];
      start = st_last && (k == pq.size() - 1);
      idx = (k > 15) ? 15 : k;
      mprog[idx] = pq[k]; mdata[idx] = dq[k];
      @(negedge clk);
    end
    load_en = 1'b0; start = 1'b0;
    model();
  endtask

  task automatic go();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic finish_run(input string nm);
    int cyc = 0;
    while (!(halted || fault) && cyc < 3000) begin @(negedge clk); cyc++; end
    if (cyc >= 3000) begin total++; bad++; $display("FAIL %s_timeout act=running exp=stopped", nm); end
    chk({nm, "_pc"}, 32'(pc), 32'(e_pc));
    chk({nm, "_halted"}, 32'(halted), 32'(e_halt));
    chk({nm, "_fault"}, 32'(fault), 32'(e_fault));
    chk({nm, "_flags"}, 32'({c_flag, z_flag, s_flag}), 32'({e_c[0], e_z[0], e_s[0]}));
    chk({nm, "_sb_left"}, 32'(exp_q.size()), 32'(0));
    chk({nm, "_in_left"}, 32'(in_q.size()), 32'(0));
  endtask

  task automatic wait_out(input string nm);
    for (int k = 0; k < 50 && !out_valid; k++) @(negedge clk);
    chk({nm, "_reach_out"}, 32'(out_valid), 32'(1));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_out", 32'({out_valid, out_data}), 0);
    chk("rst_ctl", 32'({in_ready, halted, fault}), 0);
    chk("rst_flags", 32'({c_flag, z_flag, s_flag}), 0);
    reset = 1'b1;

    // F0 + 20 -> 10 with carry
    pq = '{8'h30, 8'h20, 8'h31, 8'h00, 8'h60, 8'hF0}; dq = '{8'hF0, 8'h20};
    prep(0); go(); finish_run("add_carry");

    // 03 - 05 borrow, then TEST of the same values
    pq = '{8'h30, 8'h20, 8'h31, 8'h10, 8'h60, 8'h31, 8'h80, 8'h60, 8'hF0}; dq = '{8'h05, 8'h03};
    prep(0); go(); finish_run("sub_test");

    // endless PUSH loop: 16 succeed, 17th faults at pc=1
    pq = '{8'h30, 8'hB0, 8'hD1}; dq = '{8'h00};
    prep(0); go(); finish_run("push_ovf");

    pq = '{8'h30, 8'h20, 8'hC0, 8'h60}; dq = '{8'h5A};
    prep(0); go(); finish_run("pop_unf");

    in_zero = 1;
    pq = '{8'h50, 8'h60, 8'hF0}; dq = '{};
    prep(0); go(); finish_run("in_zero");
    in_zero = 0;

    // countdown 5 -> 0 via SUB, JZ exits
    pq = '{8'h31, 8'h20, 8'h30, 8'hE2, 8'h32, 8'h10, 8'h60, 8'hDB, 8'hE2, 8'h33, 8'hD4, 8'hF0};
    dq = '{8'h05, 8'h01, 8'h00, 8'h00};
    prep(0); go(); finish_run("jz_loop");

    pq = '{8'h30, 8'h20, 8'h31, 8'h00, 8'h60, 8'h40, 8'hA1, 8'h60,
           8'h91, 8'h70, 8'hE5, 8'h35, 8'h10, 8'h60, 8'h80, 8'h60};
    dq = '{8'h37, 8'hC9, 8'h81, 8'h00, 8'hFF, 8'h12};
    prep(0); go(); finish_run("no_hlt");

    // 17th word lands on entry 15
    pq = '{};
    for (int k = 0; k < 16; k++) pq.push_back(8'h30);
    pq.push_back(8'h60); dq = '{8'h9C};
    prep(0); go(); finish_run("load_sat");

    pq = '{8'hF0}; dq = '{};
    prep(1);
    repeat (3) @(negedge clk);
    chk("load_wins", 32'(halted), 0);
    go(); finish_run("load_start");

    pq = '{8'h30, 8'h60, 8'hF0}; dq = '{8'hA5};
    prep(0); out_stall = 1; go(); wait_out("hs");
    repeat (5) @(negedge clk);
    chk("hs_valid", 32'(out_valid), 1);
    chk("hs_data", 32'(out_data), 32'(exp_q[0].d));
    chk("hs_pc", 32'(pc), 1);
    out_stall = 0; finish_run("hs");

    pq = '{8'h30, 8'h60, 8'hF0}; dq = '{8'h3C};
    prep(0); out_stall = 1; go(); wait_out("rst_mid");
    reset = 1'b0; #1;
    chk("rst_mid_ctl", 32'({out_valid, halted, in_ready}), 0);
    chk("rst_mid_pc", 32'(pc), 0);
    out_stall = 0;
    prep(0); go(); finish_run("rerun");

    for (int r = 0; r < 25; r++) begin
      pq = '{}; dq = '{};
      for (int i = 0; i < 16; i++) begin
        int o, op;
        o = $urandom_range(15); op = $urandom_range(15);
        if (o == 13) begin
          if (i == 15) o = 0;
          else op = $urandom_range(15, i + 1);
        end
        pq.push_back(8'((o << 4) | op));
        dq.push_back(8'($urandom));
      end
      prep(0); go(); finish_run("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
